fp32_to_int32: RTL and testbench
================================

FP32_TO_INT32 -- requirements
Module: fp32_to_int32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows (clock and reset first).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active low; asserting it acts immediately, without waiting for a clock edge.
REQ-002 The block SHALL have these data and handshake ports.
- in_valid  input  1  operand available.
- in_ready  output  1  block can accept an operand.
- a  input  32  IEEE-754 single-precision operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- res  output  32  signed two's-complement integer result.
- exception  output  1  input is NaN or infinity, or the result is out of range.
- inexact  output  1  nonzero fraction bits were discarded.
REQ-003 The block SHALL have no parameters.

Function
REQ-004 Conversion SHALL truncate toward zero: res = trunc(a).
REQ-005 The control SHALL be a finite state machine with states IDLE, CLASS, SHIFT, FIX and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; an operand is accepted on a rising edge where in_valid=1 and in_ready=1, a is registered, and the state moves to CLASS.
REQ-007 CLASS SHALL decode e=a[30:23] and sig={1,a[22:0]}, load the shift count n, and classify the operand.
- e=255: result 0x7FFFFFFF if the sign is 0 or the operand is NaN, else 0x80000000; exception=1; n=0.
- a=0xCF000000 (exactly -2^31): result 0x80000000; exception=0; n=0.
- e>=158 otherwise: saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative); exception=1; n=0.
- e<127, including zero and denormals: result 0; inexact=1 if a[30:0]!=0; n=0.
- 127<=e<=150: shift right with n=150-e (0..23).
- 151<=e<=157: shift left with n=e-150 (1..7).
REQ-008 From CLASS, the next state SHALL be SHIFT if n>0, else FIX.
REQ-009 SHIFT SHALL shift a 32-bit magnitude register one bit per cycle and decrement n, moving to FIX in the cycle n reaches 0.
- Right shifts: every bit shifted out SHALL be OR-ed into the inexact flag.
- Left shifts: zeros SHALL be shifted in.
REQ-010 FIX SHALL apply the sign (two's complement of the magnitude when a[31]=1 and the operand is a normal in-range case) and then move to DONE.
REQ-011 Latency SHALL be exactly n+2 rising edges from the accepting edge to out_valid=1, where n=0 for special cases.
- Maximum latency SHALL be 25 edges (e=127).
REQ-012 In DONE, out_valid SHALL be 1 and res, exception and inexact SHALL be held stable until an edge with out_ready=1, after which the state SHALL go to IDLE and out_valid SHALL fall.
REQ-013 No input SHALL be accepted while busy; in_valid outside IDLE SHALL be ignored.
- There SHALL be no same-cycle bypass; a new operand is accepted at the earliest on the cycle after the handshake out.
REQ-014 out_valid, in_ready, res, exception and inexact SHALL all be driven from registers.
REQ-015 exception and inexact SHALL be valid only while out_valid=1.

Reset
REQ-016 While rst_n=0, the outputs SHALL be: state=IDLE, in_ready=1, out_valid=0, res=0, exception=0, inexact=0, and all internal registers cleared.
REQ-017 Asserting rst_n during CLASS, SHIFT, FIX or DONE SHALL abort the operation without producing any result.
- After rst_n is released, the block SHALL accept an operand on the first edge with in_valid=1.

Verification
REQ-018 a=0x3F800000 (1.0) with out_ready=1 -> res=0x00000001, inexact=0, exception=0, and out_valid rising 25 edges after acceptance.
REQ-019 a=0xC0490FDB (-3.14159) -> res=0xFFFFFFFD, inexact=1, exception=0, latency 24 edges.
REQ-020 a=0x4EFFFFFF -> res=0x7FFFFF80, inexact=0, latency 9 edges; a=0x4F000000 -> res=0x7FFFFFFF, exception=1, latency 2 edges.
REQ-021 Special operands SHALL give:
- a=0x7F800000 -> res=0x7FFFFFFF, exception=1.
- a=0xFF800000 -> res=0x80000000, exception=1.
- a=0x7FC00000 -> res=0x7FFFFFFF, exception=1.
- a=0xCF000000 -> res=0x80000000, exception=0.
- a=0x3F000000 -> res=0, inexact=1.
- a=0x80000000 -> res=0, inexact=0.
REQ-022 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, res and flags stay stable, in_ready stays 0 and in_valid pulses are ignored; raising out_ready completes the handshake and in_ready=1 on the next cycle.
REQ-023 Reset mid-operation: assert rst_n=0 during SHIFT of a=0x3F800000 -> out_valid=0 and in_ready=1 immediately; after release, a=0x40A00000 converts to res=0x00000005.

Source files
------------

// File: rtl/fp32_to_int32.sv
// rtl/fp32_to_int32.sv - IEEE-754 single to signed int32 converter, truncating, bit-serial shifter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand available
//   in_ready   block can accept an operand (IDLE only)
//   a          fp32 operand
//   out_valid  result available, held until out_ready
//   out_ready  consumer accepts the result
//   res        two's-complement integer result, trunc(a)
//   exception  NaN/infinity or out-of-range operand
//   inexact    nonzero fraction bits were discarded

module fp32_to_int32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        exception,
  output logic        inexact
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLASS = 3'd1,
    SHIFT = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [31:0] a_q;
  logic [31:0] mag;
  logic [4:0]  cnt;
  logic        left;
  logic        neg;

  // Classification of the registered operand, consumed in CLASS
  logic [7:0]  e;
  logic [22:0] frac;
  logic [31:0] c_mag;
  logic [4:0]  c_n;
  logic        c_left;
  logic        c_exc;
  logic        c_inx;
  logic        c_neg;

  assign e    = a_q[30:23];
  assign frac = a_q[22:0];

  always_comb begin
    c_mag  = 32'd0;
    c_n    = 5'd0;
    c_left = 1'b0;
    c_exc  = 1'b0;
    c_inx  = 1'b0;
    c_neg  = 1'b0;
    if (e == 8'd255) begin
      // NaN saturates positive regardless of sign
      c_exc = 1'b1;
      c_mag = (!a_q[31] || frac != 23'd0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else if (a_q == 32'hCF00_0000) begin
      // -2^31 is the only representable value with e=158
      c_mag = 32'h8000_0000;
    end else if (e >= 8'd158) begin
      c_exc = 1'b1;
      c_mag = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e < 8'd127) begin
      c_inx = (a_q[30:0] != 31'd0);
    end else if (e <= 8'd150) begin
      c_mag = {8'd0, 1'b1, frac};
      c_n   = 5'(8'd150 - e);
      c_neg = a_q[31];
    end else begin
      c_mag  = {8'd0, 1'b1, frac};
      c_n    = 5'(e - 8'd150);
      c_left = 1'b1;
      c_neg  = a_q[31];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CLASS;
      CLASS:   state_next = (c_n != 5'd0) ? SHIFT : FIX;
      SHIFT:   if (cnt == 5'd1) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= 32'd0;
      mag       <= 32'd0;
      cnt       <= 5'd0;
      left      <= 1'b0;
      neg       <= 1'b0;
      res       <= 32'd0;
      exception <= 1'b0;
      inexact   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            in_ready <= 1'b0;
          end
        end
        CLASS: begin
          mag       <= c_mag;
          cnt       <= c_n;
          left      <= c_left;
          neg       <= c_neg;
          exception <= c_exc;
          inexact   <= c_inx;
        end
        SHIFT: begin
          cnt <= cnt - 5'd1;
          if (left) begin
            mag <= {mag[30:0], 1'b0};
          end else begin
            mag     <= {1'b0, mag[31:1]};
            inexact <= inexact | mag[0];
          end
        end
        FIX: begin
          res       <= neg ? (~mag + 32'd1) : mag;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_int32.sv
// tb/tb_fp32_to_int32.sv - directed-vector bench for fp32_to_int32

module tb_fp32_to_int32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        exception;
  logic        inexact;

  int n_vec;
  int n_bad;

  fp32_to_int32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .exception (exception),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch an operand, wait for out_valid, check latency and result.
  // Leaves the bench sampling #1 after the edge on which out_valid rose.
  task automatic launch_and_wait(input logic [31:0] val, input string tag, output int lat);
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    a        = val;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic convert(input logic [31:0] val, input logic [31:0] exp_res,
                         input logic exp_exc, input logic exp_inx,
                         input int exp_lat, input string tag);
    int lat;
    out_ready = 1'b1;
    launch_and_wait(val, tag, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " res"}, res, exp_res);
    check({tag, " exception"}, {31'd0, exception}, {31'd0, exp_exc});
    check({tag, " inexact"}, {31'd0, inexact}, {31'd0, exp_inx});
    @(posedge clk);
    #1;
    check({tag, " out_valid_fall"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 32'd0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst res", res, 32'd0);
    check("rst exception", {31'd0, exception}, 32'd0);
    check("rst inexact", {31'd0, inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25, "one");
    convert(32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 24, "neg_pi");
    convert(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9,  "max_left");
    convert(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2,  "pos_2p31");
    convert(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2,  "pos_inf");
    convert(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2,  "neg_inf");
    convert(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2,  "qnan");
    convert(32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2,  "neg_nan");
    convert(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2,  "neg_2p31");
    convert(32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 2,  "neg_over");
    convert(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2,  "half");
    convert(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2,  "neg_zero");
    convert(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2,  "denorm");
    convert(32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2,  "two_p23");
    convert(32'hCB00_0001, 32'hFF7F_FFFF, 1'b0, 1'b0, 2,  "neg_2p23p1");
    convert(32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 25, "minus_one");
    convert(32'h4B80_0001, 32'h0100_0002, 1'b0, 1'b0, 3,  "left_one");

    // Backpressure: result held, inputs ignored while DONE
    out_ready = 1'b0;
    launch_and_wait(32'h40A0_0000, "bp", lat);
    check("bp latency", lat, 23);
    check("bp res", res, 32'h0000_0005);
    held = res;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a        = 32'h4780_0000 + i;
      @(posedge clk);
      #1;
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp res_hold", res, held);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      check("bp flags", {30'd0, exception, inexact}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp out_valid_fall", {31'd0, out_valid}, 32'd0);
    check("bp in_ready_back", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp no_spurious", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a long right shift
    @(negedge clk);
    a        = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    convert(32'h40A0_0000, 32'h0000_0005, 1'b0, 1'b0, 23, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
